// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the UART boot loader.
package uart_loader_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_RUN
  } state_t;

  localparam byte_t SYNC_BYTE_DEF      = 8'hA5;
  localparam int    TIMEOUT_CYCLES_DEF = 17360;

  // States in which the inter-byte watchdog is armed.
  function automatic logic in_frame(input state_t s);
    return (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/uart_loader_byte_timer.sv
// Inter-byte watchdog: down-counter reloaded on every byte, expires
// TIMEOUT_CYCLES clocks after the last clear while enabled.
module byte_timer
  import uart_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // Loaded with N-1 so the terminal count is seen on the Nth clock after clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= CW'(TIMEOUT_CYCLES - 1);
    end else if (i_enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = i_enable && (r_cnt == '0);

endmodule

// File: rtl/uart_loader.sv
// Boot-load sequencer: receives SYNC,LEN,data,CHECKSUM from the UART and
// writes imem from address 0. Optional reload from RUN: UART_LOADER_RELOAD_EN.
//
// state  | meaning
// IDLE   | waiting for SYNC, CPU held in reset
// LEN    | waiting for length byte
// DATA   | writing data bytes to imem
// CSUM   | waiting for checksum byte
// RUN    | image accepted, CPU released
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int    ADDR_W         = 8,
  parameter byte_t SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int    TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_count;
  logic [7:0]        r_sum;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_cpu_rst_n;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic w_timer_en;
  logic w_expired;

  assign w_timer_en = in_frame(r_state);

  byte_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (rx_valid),
    .i_enable  (w_timer_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_count     <= '0;
      r_sum       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rst_n <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_we <= 1'b0;
      // A byte arriving on the expiry cycle takes priority over the timeout.
      if (w_timer_en && !rx_valid && w_expired) begin
        r_state <= S_IDLE;
        r_err   <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
              r_state <= S_LEN;
              r_err   <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          S_LEN: begin
            if (rx_valid) begin
              r_count <= rx_data;
              r_sum   <= '0;
              r_ptr   <= '0;
              r_addr  <= '0;
              r_state <= (rx_data == 8'h00) ? S_CSUM : S_DATA;
            end
          end
          S_DATA: begin
            if (rx_valid) begin
              r_we    <= 1'b1;
              r_wdata <= rx_data;
              r_addr  <= r_ptr;
              r_ptr   <= r_ptr + 1'b1;
              r_sum   <= r_sum + rx_data;
              r_count <= r_count - 1'b1;
              if (r_count == 8'd1) r_state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (rx_valid) begin
              r_busy <= 1'b0;
              if (rx_data == r_sum) begin
                r_state     <= S_RUN;
                r_cpu_rst_n <= 1'b1;
                r_done      <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_err   <= 1'b1;
              end
            end
          end
          S_RUN: begin
`ifdef UART_LOADER_RELOAD_EN
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
              r_state     <= S_LEN;
              r_cpu_rst_n <= 1'b0;
              r_done      <= 1'b0;
              r_busy      <= 1'b1;
              r_err       <= 1'b0;
            end
`else
            r_state <= S_RUN;
`endif
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_rst_n  = r_cpu_rst_n;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_uart_loader.sv
// Directed self-checking bench for uart_loader (frame load, checksum error,
// timeout, async reset, optional reload under UART_LOADER_RELOAD_EN).
module tb_uart_loader;

  localparam int T = 17360;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       cpu_rst_n, busy, done, err;

  int checks = 0;
  int failures = 0;
  int n_wr = 0;
  logic [7:0] mem_img [0:255];

  always #5 clk = ~clk;

  uart_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      mem_img[imem_addr] = imem_wdata;
      n_wr = n_wr + 1;
    end
  end

  // Called at a negedge; byte is sampled on the following posedge.
  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL rst_we: got %b expected 0", imem_we); end
    checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL rst_addr: got %h expected 00", imem_addr); end
    checks++; if (imem_wdata !== 8'h00) begin failures++; $display("FAIL rst_wdata: got %h expected 00", imem_wdata); end
    checks++; if ({cpu_rst_n, busy, done, err} !== 4'b0000) begin failures++; $display("FAIL rst_ctl: got %b expected 0000", {cpu_rst_n, busy, done, err}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    int base;
    base = n_wr;
    put(8'hA5);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL good_busy: got %b expected 1", busy); end
    put(8'h03); put(8'h11); put(8'h22); put(8'h33);
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL good_cpu_held: got %b expected 0", cpu_rst_n); end
    put(8'h66);
    checks++; if ({cpu_rst_n, done, busy, err} !== 4'b1100) begin failures++; $display("FAIL good_release: got %b expected 1100", {cpu_rst_n, done, busy, err}); end
    checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL good_we_idle: got %b expected 0", imem_we); end
    checks++; if (n_wr - base !== 3) begin failures++; $display("FAIL good_nwr: got %0d expected 3", n_wr - base); end
    checks++; if ({mem_img[0], mem_img[1], mem_img[2]} !== 24'h112233) begin failures++; $display("FAIL good_mem: got %h expected 112233", {mem_img[0], mem_img[1], mem_img[2]}); end
  endtask

  task automatic test_bad_then_good();
    do_reset();
    put(8'hA5); put(8'h02); put(8'h10); put(8'h20); put(8'h00);
    checks++; if ({err, busy, cpu_rst_n, done} !== 4'b1000) begin failures++; $display("FAIL bad_csum: got %b expected 1000", {err, busy, cpu_rst_n, done}); end
    put(8'hA5);
    checks++; if ({err, busy} !== 2'b01) begin failures++; $display("FAIL bad_err_clear: got %b expected 01", {err, busy}); end
    put(8'h01); put(8'h05); put(8'h05);
    checks++; if ({err, cpu_rst_n, done} !== 3'b011) begin failures++; $display("FAIL bad_recover: got %b expected 011", {err, cpu_rst_n, done}); end
    checks++; if (mem_img[0] !== 8'h05) begin failures++; $display("FAIL bad_recover_mem: got %h expected 05", mem_img[0]); end
  endtask

  task automatic test_leading_zero_len();
    int base;
    do_reset();
    base = n_wr;
    put(8'h00); put(8'hFF); put(8'h5A);
    checks++; if ({busy, err} !== 2'b00) begin failures++; $display("FAIL lead_ignored: got %b expected 00", {busy, err}); end
    put(8'hA5); put(8'h00); put(8'h00);
    checks++; if ({cpu_rst_n, done, busy} !== 3'b110) begin failures++; $display("FAIL zero_len_run: got %b expected 110", {cpu_rst_n, done, busy}); end
    @(negedge clk);
    checks++; if (n_wr - base !== 0) begin failures++; $display("FAIL zero_len_nwr: got %0d expected 0", n_wr - base); end
  endtask

  task automatic test_run_sync();
    int base;
    base = n_wr;
`ifdef UART_LOADER_RELOAD_EN
    put(8'hA5);
    checks++; if ({cpu_rst_n, done, busy} !== 3'b001) begin failures++; $display("FAIL reload_drop: got %b expected 001", {cpu_rst_n, done, busy}); end
    put(8'h01); put(8'hAA); put(8'hAA);
    checks++; if ({cpu_rst_n, done, err} !== 3'b110) begin failures++; $display("FAIL reload_release: got %b expected 110", {cpu_rst_n, done, err}); end
    @(negedge clk);
    checks++; if (n_wr - base !== 1) begin failures++; $display("FAIL reload_nwr: got %0d expected 1", n_wr - base); end
    checks++; if (mem_img[0] !== 8'hAA) begin failures++; $display("FAIL reload_mem: got %h expected AA", mem_img[0]); end
`else
    put(8'hA5);
    checks++; if ({cpu_rst_n, done, busy} !== 3'b110) begin failures++; $display("FAIL run_hold: got %b expected 110", {cpu_rst_n, done, busy}); end
    put(8'h01); put(8'hAA); put(8'hAA);
    @(negedge clk);
    checks++; if ({cpu_rst_n, done, busy, err} !== 4'b1100) begin failures++; $display("FAIL run_ignore: got %b expected 1100", {cpu_rst_n, done, busy, err}); end
    checks++; if (n_wr - base !== 0) begin failures++; $display("FAIL run_nwr: got %0d expected 0", n_wr - base); end
`endif
  endtask

  task automatic test_timeout();
    do_reset();
    put(8'hA5); put(8'h04); put(8'h01); put(8'h02);
    repeat (T - 1) @(negedge clk);
    checks++; if ({err, busy} !== 2'b01) begin failures++; $display("FAIL to_before: got %b expected 01", {err, busy}); end
    @(negedge clk);
    checks++; if ({err, busy, cpu_rst_n} !== 3'b100) begin failures++; $display("FAIL to_expire: got %b expected 100", {err, busy, cpu_rst_n}); end
    put(8'hA5); put(8'h04); put(8'h01); put(8'h02);
    repeat (T - 1) @(negedge clk);
    put(8'h03);
    checks++; if ({err, busy} !== 2'b01) begin failures++; $display("FAIL to_byte_wins: got %b expected 01", {err, busy}); end
    put(8'h04); put(8'h0A);
    checks++; if ({err, done, cpu_rst_n} !== 3'b011) begin failures++; $display("FAIL to_frame_ok: got %b expected 011", {err, done, cpu_rst_n}); end
    checks++; if ({mem_img[2], mem_img[3]} !== 16'h0304) begin failures++; $display("FAIL to_mem: got %h expected 0304", {mem_img[2], mem_img[3]}); end
  endtask

  task automatic test_midframe_reset();
    int base;
    do_reset();
    base = n_wr;
    put(8'hA5); put(8'h03); put(8'hAA); put(8'hBB);
    checks++; if ({imem_we, busy} !== 2'b11) begin failures++; $display("FAIL mid_pre: got %b expected 11", {imem_we, busy}); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({imem_we, imem_addr, imem_wdata} !== 17'h0) begin failures++; $display("FAIL mid_async_data: got %h expected 0", {imem_we, imem_addr, imem_wdata}); end
    checks++; if ({cpu_rst_n, busy, done, err} !== 4'b0000) begin failures++; $display("FAIL mid_async_ctl: got %b expected 0000", {cpu_rst_n, busy, done, err}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    put(8'hA5); put(8'h02); put(8'hA5); put(8'hC2); put(8'h67);
    checks++; if ({cpu_rst_n, done, err} !== 3'b110) begin failures++; $display("FAIL mid_reload: got %b expected 110", {cpu_rst_n, done, err}); end
    checks++; if ({mem_img[0], mem_img[1]} !== 16'hA5C2) begin failures++; $display("FAIL mid_mem: got %h expected A5C2", {mem_img[0], mem_img[1]}); end
    checks++; if (n_wr - base !== 4) begin failures++; $display("FAIL mid_nwr: got %0d expected 4", n_wr - base); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_then_good();
    test_leading_zero_len();
    test_run_sync();
    test_timeout();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
